// File: rtl/clk_ratio_checker.sv
// Measures the period of an asynchronous divided clock in clk50 cycles, emits a
// qualified rise pulse per edge, and tracks lock / sticky loss-of-lock errors.
module clk_ratio_checker #(
  parameter int unsigned RATIO      = 16,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             clr_err,
  output logic             rise_pulse,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] period,
  output logic [7:0]       err_count
);

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(RATIO - TOL);
  localparam logic [CNT_W-1:0] HI_LIM = CNT_W'(RATIO + TOL);
  localparam logic [GW-1:0]    LOCK_N = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_LOCKED
  } state_t;

  state_t           r_state;
  logic             r_sync0;
  logic             r_sync1;
  logic             r_s1_d;
  logic [CNT_W-1:0] r_cnt;
  logic [GW-1:0]    r_good_cnt;
  logic             r_rise_pulse;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_period;
  logic [7:0]       r_err_count;

  logic             w_rise;
  logic             w_good;
  logic             w_timeout;
  logic             w_loss;
  logic             w_cnt_max;
  logic [GW-1:0]    w_good_nxt;
  logic [7:0]       w_ecnt_inc;

  assign w_rise     = r_sync1 & ~r_s1_d;
  assign w_good     = (r_cnt >= LO_LIM) && (r_cnt <= HI_LIM);
  // A rise on the timeout edge is a real measurement, so it suppresses the timeout.
  assign w_timeout  = ~w_rise && (r_cnt == HI_LIM);
  assign w_loss     = (r_state == ST_LOCKED) && (w_rise ? ~w_good : w_timeout);
  assign w_cnt_max  = &r_cnt;
  assign w_good_nxt = r_good_cnt + GW'(1);
  assign w_ecnt_inc = (&r_err_count) ? r_err_count : r_err_count + 8'd1;

  always_ff @(posedge clk50) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_sync0      <= 1'b0;
      r_sync1      <= 1'b0;
      r_s1_d       <= 1'b0;
      r_cnt        <= '0;
      r_good_cnt   <= '0;
      r_rise_pulse <= 1'b0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_period     <= '0;
      r_err_count  <= '0;
    end else begin
      r_sync0      <= clk_in;
      r_sync1      <= r_sync0;
      r_s1_d       <= r_sync1;
      r_rise_pulse <= w_rise;

      if (w_rise) begin
        r_cnt <= CNT_W'(1);
      end else if (!w_cnt_max) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // A loss-of-lock in the same cycle as clr_err must still be recorded.
      if (w_loss) begin
        r_err       <= 1'b1;
        r_err_count <= clr_err ? 8'd1 : w_ecnt_inc;
      end else if (clr_err) begin
        r_err       <= 1'b0;
        r_err_count <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          r_locked <= 1'b0;
          if (w_rise) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= '0;
          end
        end
        ST_SEARCH: begin
          if (w_rise) begin
            r_period <= r_cnt;
            if (w_good) begin
              r_good_cnt <= w_good_nxt;
              if (w_good_nxt == LOCK_N) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_good_cnt <= '0;
            end
          end else if (w_timeout) begin
            r_good_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_rise) begin
            r_period <= r_cnt;
          end
          if (w_loss) begin
            r_state    <= ST_SEARCH;
            r_locked   <= 1'b0;
            r_good_cnt <= '0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign rise_pulse = r_rise_pulse;
  assign locked     = r_locked;
  assign err        = r_err;
  assign period     = r_period;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_clk_ratio_checker.sv
// Bench for clk_ratio_checker: a TOL=0 and a TOL=1 instance checked every cycle
// against an edge-timestamp reference model, plus directed scenario checks.
module tb_clk_ratio_checker;

  localparam int CW = 8;

  logic          clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  logic          a_rst = 1'b1, a_cin = 1'b0, a_clr = 1'b0;
  logic          a_pulse, a_locked, a_err;
  logic [CW-1:0] a_period;
  logic [7:0]    a_ecnt;
  logic          b_rst = 1'b1, b_cin = 1'b0, b_clr = 1'b0;
  logic          b_pulse, b_locked, b_err;
  logic [CW-1:0] b_period;
  logic [7:0]    b_ecnt;

  clk_ratio_checker #(.RATIO(16), .TOL(0), .LOCK_COUNT(4), .CNT_W(CW)) u_dut_a (
    .clk50(clk50), .reset(a_rst), .clk_in(a_cin), .clr_err(a_clr),
    .rise_pulse(a_pulse), .locked(a_locked), .err(a_err),
    .period(a_period), .err_count(a_ecnt)
  );

  clk_ratio_checker #(.RATIO(16), .TOL(1), .LOCK_COUNT(4), .CNT_W(CW)) u_dut_b (
    .clk50(clk50), .reset(b_rst), .clk_in(b_cin), .clr_err(b_clr),
    .rise_pulse(b_pulse), .locked(b_locked), .err(b_err),
    .period(b_period), .err_count(b_ecnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: measured period is the distance in edges between
  // successive detected rises; detection sees the sample taken two edges back.
  int m_tol [2] = '{0, 1};
  bit h1 [2], h2 [2], h3 [2];
  int anchor [2];
  int mode [2];      // 0 idle, 1 searching, 2 locked
  int streak [2];
  int e_pulse [2], e_locked [2], e_err [2], e_ecnt [2], e_per [2];
  int edge_no = 0;
  bit drv_clk [2], drv_rst [2], drv_clr [2];

  task automatic model_step(input int i, input bit rst, input bit cin, input bit clr);
    int  c;
    int  hi;
    int  lo;
    bit  rise;
    bit  lol;
    hi = 16 + m_tol[i];
    lo = 16 - m_tol[i];
    if (rst) begin
      h1[i] = 0; h2[i] = 0; h3[i] = 0;
      anchor[i] = edge_no + 1;
      mode[i] = 0; streak[i] = 0;
      e_pulse[i] = 0; e_locked[i] = 0; e_err[i] = 0; e_ecnt[i] = 0; e_per[i] = 0;
      return;
    end
    rise = h2[i] && !h3[i];
    c = edge_no - anchor[i];
    if (c > 255) c = 255;
    lol = 0;
    if (rise) begin
      anchor[i] = edge_no;
      if (mode[i] == 0) begin
        mode[i] = 1; streak[i] = 0;
      end else begin
        e_per[i] = c;
        if (c >= lo && c <= hi) begin
          if (mode[i] == 1) begin
            streak[i]++;
            if (streak[i] == 4) mode[i] = 2;
          end
        end else begin
          lol = (mode[i] == 2);
          mode[i] = 1; streak[i] = 0;
        end
      end
    end else if (mode[i] != 0 && c == hi) begin
      lol = (mode[i] == 2);
      mode[i] = 1; streak[i] = 0;
    end
    if (clr) begin
      e_err[i] = 0; e_ecnt[i] = 0;
    end
    if (lol) begin
      e_err[i] = 1;
      e_ecnt[i] = (e_ecnt[i] >= 255) ? 255 : e_ecnt[i] + 1;
    end
    e_pulse[i]  = rise;
    e_locked[i] = (mode[i] == 2);
    h3[i] = h2[i]; h2[i] = h1[i]; h1[i] = cin;
  endtask

  task automatic tick();
    @(negedge clk50);
    a_rst = drv_rst[0]; a_cin = drv_clk[0]; a_clr = drv_clr[0];
    b_rst = drv_rst[1]; b_cin = drv_clk[1]; b_clr = drv_clr[1];
    @(posedge clk50);
    edge_no++;
    model_step(0, drv_rst[0], drv_clk[0], drv_clr[0]);
    model_step(1, drv_rst[1], drv_clk[1], drv_clr[1]);
    #1;
    chk("a_pulse",  a_pulse,  e_pulse[0]);
    chk("a_locked", a_locked, e_locked[0]);
    chk("a_err",    a_err,    e_err[0]);
    chk("a_ecnt",   a_ecnt,   e_ecnt[0]);
    chk("a_period", a_period, e_per[0]);
    chk("b_pulse",  b_pulse,  e_pulse[1]);
    chk("b_locked", b_locked, e_locked[1]);
    chk("b_err",    b_err,    e_err[1]);
    chk("b_ecnt",   b_ecnt,   e_ecnt[1]);
    chk("b_period", b_period, e_per[1]);
  endtask

  task automatic run_period(input int i, input int p, input int h);
    for (int j = 0; j < p; j++) begin
      drv_clk[i] = (j < h);
      tick();
    end
  endtask

  task automatic hold(input int i, input bit v, input int n);
    for (int j = 0; j < n; j++) begin
      drv_clk[i] = v;
      tick();
    end
  endtask

  initial begin
    int p;
    int pulses;
    drv_rst = '{1, 1};
    drv_clk = '{0, 0};
    drv_clr = '{0, 0};
    repeat (3) tick();
    chk("rst_a_locked", a_locked, 0);
    chk("rst_a_period", a_period, 0);
    chk("rst_a_ecnt",   a_ecnt,   0);
    drv_rst = '{0, 0};
    hold(0, 0, 4);

    // Clean ratio clock: lock on the 5th rise, counting pulses as they come.
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 16; j++) begin
        drv_clk[0] = (j < 8);
        tick();
        if (j == 2) begin
          pulses++;
          chk("clean_pulse", a_pulse, 1);
          chk("clean_lock", a_locked, (pulses >= 5) ? 1 : 0);
        end
        if (j == 3) chk("clean_width", a_pulse, 0);
      end
    end
    chk("clean_period", a_period, 16);
    chk("clean_err", a_err, 0);

    // One long period: lost at its timeout, measured 18 at the following rise.
    run_period(0, 18, 9);
    run_period(0, 16, 8);
    chk("long_period", a_period, 18);
    chk("long_locked", a_locked, 0);
    chk("long_err", a_err, 1);
    chk("long_ecnt", a_ecnt, 1);
    repeat (3) run_period(0, 16, 8);
    chk("relock_not_yet", a_locked, 0);
    run_period(0, 16, 8);
    chk("relock", a_locked, 1);

    drv_clr[0] = 1;
    run_period(0, 16, 8);
    drv_clr[0] = 0;
    chk("clr_err", a_err, 0);
    chk("clr_ecnt", a_ecnt, 0);

    // Stopped clock: timeout 16 edges after the last rise condition.
    hold(0, 0, 2);
    chk("stop_before", a_locked, 1);
    hold(0, 0, 1);
    chk("stop_locked", a_locked, 0);
    chk("stop_err", a_err, 1);
    chk("stop_ecnt", a_ecnt, 1);
    chk("stop_period", a_period, 16);
    chk("stop_pulse", a_pulse, 0);
    hold(0, 0, 30);
    chk("stop_once", a_ecnt, 1);
    repeat (6) run_period(0, 16, 8);
    chk("stop_relock", a_locked, 1);

    // Loss-of-lock coincident with clr_err.
    hold(0, 0, 2);
    drv_clr[0] = 1;
    hold(0, 0, 1);
    chk("coinc_err", a_err, 1);
    chk("coinc_ecnt", a_ecnt, 1);
    hold(0, 0, 1);
    drv_clr[0] = 0;
    chk("clr_alone_err", a_err, 0);
    chk("clr_alone_ecnt", a_ecnt, 0);
    repeat (6) run_period(0, 16, $urandom_range(2, 14));

    // Random period sweep.
    for (int k = 0; k < 60; k++) begin
      p = $urandom_range(6, 24);
      run_period(0, p, $urandom_range(2, p - 2));
    end
    repeat (6) run_period(0, 16, $urandom_range(2, 14));

    // 300 loss-of-lock events: saturate err_count.
    for (int k = 0; k < 300; k++) begin
      p = ($urandom_range(0, 1) == 0) ? $urandom_range(4, 15) : $urandom_range(17, 30);
      run_period(0, p, $urandom_range(2, p - 2));
      repeat (5) run_period(0, 16, $urandom_range(2, 14));
    end
    chk("sat_ecnt", a_ecnt, 255);
    chk("sat_err", a_err, 1);
    chk("sat_locked", a_locked, 1);

    // One-cycle reset while locked, clock keeps running in its low phase.
    for (int j = 0; j < 16; j++) begin
      drv_clk[0] = (j < 8);
      drv_rst[0] = (j == 10);
      tick();
      if (j == 10) begin
        chk("mrst_locked", a_locked, 0);
        chk("mrst_err", a_err, 0);
        chk("mrst_ecnt", a_ecnt, 0);
        chk("mrst_period", a_period, 0);
        chk("mrst_pulse", a_pulse, 0);
      end
    end
    drv_rst[0] = 0;
    repeat (4) run_period(0, 16, 8);
    chk("mrst_4th", a_locked, 0);
    run_period(0, 16, 8);
    chk("mrst_5th", a_locked, 1);
    hold(0, 0, 4);

    // TOL=1 instance: tolerate 15/17, lose lock on 14.
    repeat (6) run_period(1, 16, 8);
    chk("tol_lock", b_locked, 1);
    for (int k = 0; k < 10; k++) begin
      run_period(1, 15, 7);
      run_period(1, 17, 8);
    end
    chk("tol_alt_locked", b_locked, 1);
    chk("tol_alt_err", b_err, 0);
    run_period(1, 14, 7);
    run_period(1, 16, 8);
    chk("tol_short_locked", b_locked, 0);
    chk("tol_short_err", b_err, 1);
    chk("tol_short_period", b_period, 14);
    chk("tol_short_ecnt", b_ecnt, 1);
    repeat (5) run_period(1, 16, 8);
    chk("tol_relock", b_locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
